// File: rtl/conv_layer_scheduler.sv
// rtl/conv_layer_scheduler.sv - layer sequencer running the convolution control unit once per output channel.
// Define CONV_SCHED_PERF_EN to add the saturating busy-cycle counter perf_cycles.
module conv_layer_scheduler #(
  parameter int OUT_CH_W   = 9,
  parameter int RST_CYCLES = 4
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          cfg_channel_choose,
  input  logic [2:0]          cfg_image_choose,
  input  logic [OUT_CH_W-1:0] cfg_out_channels,
  input  logic                cu_slave_select,
  input  logic                cu_conv_DONE,
  input  logic                drain_done,
  output logic                cu_reset_n,
  output logic                Load_kernel_BRAM,
  output logic [1:0]          CHANNEL_SIZE_choose,
  output logic [2:0]          IMAGE_SIZE_choose,
  output logic                drain_req,
  output logic [OUT_CH_W-1:0] out_ch_idx,
  output logic                busy,
`ifdef CONV_SCHED_PERF_EN
  output logic [31:0]         perf_cycles,
`endif
  output logic                layer_done
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CU_RST,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t              state;
  logic [RCW-1:0]      rst_cnt;
  logic [OUT_CH_W-1:0] out_ch_cnt;
  logic [OUT_CH_W-1:0] last_idx;

  assign last_idx = out_ch_cnt - OUT_CH_W'(1);

  // Outputs are written together with the state they belong to, so each one
  // is a registered function of the state just entered.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state               <= S_IDLE;
      rst_cnt             <= '0;
      out_ch_cnt          <= OUT_CH_W'(1);
      out_ch_idx          <= '0;
      CHANNEL_SIZE_choose <= '0;
      IMAGE_SIZE_choose   <= '0;
      cu_reset_n          <= 1'b1;
      Load_kernel_BRAM    <= 1'b0;
      drain_req           <= 1'b0;
      busy                <= 1'b0;
      layer_done          <= 1'b0;
    end else if (abort) begin
      state            <= S_IDLE;
      cu_reset_n       <= 1'b0;
      Load_kernel_BRAM <= 1'b0;
      drain_req        <= 1'b0;
      busy             <= 1'b0;
      layer_done       <= 1'b0;
    end else begin
      layer_done <= 1'b0;
      case (state)
        S_IDLE: begin
          cu_reset_n <= 1'b1;
          if (start) begin
            CHANNEL_SIZE_choose <= cfg_channel_choose;
            IMAGE_SIZE_choose   <= cfg_image_choose;
            out_ch_cnt          <= (cfg_out_channels == '0) ? OUT_CH_W'(1) : cfg_out_channels;
            out_ch_idx          <= '0;
            rst_cnt             <= '0;
            cu_reset_n          <= 1'b0;
            busy                <= 1'b1;
            state               <= S_CU_RST;
          end
        end
        S_CU_RST: begin
          if (rst_cnt == RST_LAST) begin
            cu_reset_n       <= 1'b1;
            Load_kernel_BRAM <= 1'b1;
            state            <= S_LOAD;
          end else begin
            rst_cnt <= rst_cnt + RCW'(1);
          end
        end
        // slave_select low means the control unit has taken the kernel load
        S_LOAD: begin
          if (!cu_slave_select) begin
            Load_kernel_BRAM <= 1'b0;
            state            <= S_RUN;
          end
        end
        S_RUN: begin
          if (cu_conv_DONE) begin
            drain_req <= 1'b1;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_done) begin
            drain_req <= 1'b0;
            if (out_ch_idx == last_idx) begin
              layer_done <= 1'b1;
              state      <= S_FIN;
            end else begin
              out_ch_idx <= out_ch_idx + OUT_CH_W'(1);
              rst_cnt    <= '0;
              cu_reset_n <= 1'b0;
              state      <= S_CU_RST;
            end
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          cu_reset_n       <= 1'b1;
          Load_kernel_BRAM <= 1'b0;
          drain_req        <= 1'b0;
          busy             <= 1'b0;
          state            <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CONV_SCHED_PERF_EN
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      perf_cycles <= '0;
    end else if (state == S_IDLE && start && !abort) begin
      perf_cycles <= '0;
    end else if (busy && perf_cycles != 32'hFFFF_FFFF) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// tb/tb_conv_layer_scheduler.sv - randomized self-checking bench for conv_layer_scheduler.
// Define CONV_SCHED_PERF_EN to also check perf_cycles.
module tb_conv_layer_scheduler;
  localparam int OUT_CH_W   = 9;
  localparam int RST_CYCLES = 4;

  logic                clk = 1'b0;
  logic                Reset;
  logic                start;
  logic                abort;
  logic [1:0]          cfg_channel_choose;
  logic [2:0]          cfg_image_choose;
  logic [OUT_CH_W-1:0] cfg_out_channels;
  logic                cu_slave_select;
  logic                cu_conv_DONE;
  logic                drain_done;
  logic                cu_reset_n;
  logic                Load_kernel_BRAM;
  logic [1:0]          CHANNEL_SIZE_choose;
  logic [2:0]          IMAGE_SIZE_choose;
  logic                drain_req;
  logic [OUT_CH_W-1:0] out_ch_idx;
  logic                busy;
  logic                layer_done;
`ifdef CONV_SCHED_PERF_EN
  logic [31:0]         perf_cycles;
`endif

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_ch;
  logic [2:0] exp_img;

  always #5 clk = ~clk;

  conv_layer_scheduler #(.OUT_CH_W(OUT_CH_W), .RST_CYCLES(RST_CYCLES)) dut (
    .clk                 (clk),
    .Reset               (Reset),
    .start               (start),
    .abort               (abort),
    .cfg_channel_choose  (cfg_channel_choose),
    .cfg_image_choose    (cfg_image_choose),
    .cfg_out_channels    (cfg_out_channels),
    .cu_slave_select     (cu_slave_select),
    .cu_conv_DONE        (cu_conv_DONE),
    .drain_done          (drain_done),
    .cu_reset_n          (cu_reset_n),
    .Load_kernel_BRAM    (Load_kernel_BRAM),
    .CHANNEL_SIZE_choose (CHANNEL_SIZE_choose),
    .IMAGE_SIZE_choose   (IMAGE_SIZE_choose),
    .drain_req           (drain_req),
    .out_ch_idx          (out_ch_idx),
    .busy                (busy),
`ifdef CONV_SCHED_PERF_EN
    .perf_cycles         (perf_cycles),
`endif
    .layer_done          (layer_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cfg();
    chk("chan_code", 32'(CHANNEL_SIZE_choose), 32'(exp_ch));
    chk("img_code", 32'(IMAGE_SIZE_choose), 32'(exp_img));
  endtask

  task automatic scramble_cfg();
    logic [31:0] r;
    r = $urandom;
    cfg_channel_choose = r[1:0];
    cfg_image_choose   = r[4:2];
    cfg_out_channels   = r[16:8];
  endtask

  // One layer as seen from the control unit and drain path: the expected
  // output at every cycle follows from the sequence rules, not the RTL.
  task automatic run_layer(input logic [1:0] ch, input logic [2:0] img, input int n_cfg,
                           input int ack_lat, input int done_lat, input int drain_lat,
                           input bit noisy, input int abort_ch);
    int n_eff;
    int perf_exp;
    logic [31:0] r;
    n_eff = (n_cfg == 0) ? 1 : n_cfg;
    r = 32'(n_cfg);
    cfg_channel_choose = ch;
    cfg_image_choose   = img;
    cfg_out_channels   = r[OUT_CH_W-1:0];
    chk("pre_busy", 32'(busy), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_ch = ch;
    exp_img = img;
    perf_exp = 0;
    for (int c = 0; c < n_eff; c++) begin
      for (int k = 0; k < RST_CYCLES; k++) begin
        chk("rst_low", 32'(cu_reset_n), 0);
        chk("rst_idx", 32'(out_ch_idx), 32'(c));
        chk("rst_busy", 32'(busy), 1);
        chk("rst_load", 32'(Load_kernel_BRAM), 0);
        chk("rst_drain", 32'(drain_req), 0);
        check_cfg();
        if (noisy) scramble_cfg();
        tick();
        perf_exp++;
      end
      for (int j = 0; j <= ack_lat; j++) begin
        chk("load_req", 32'(Load_kernel_BRAM), 1);
        chk("load_rstn", 32'(cu_reset_n), 1);
        check_cfg();
        cu_slave_select = (j == ack_lat) ? 1'b0 : 1'b1;
        if (noisy && j < ack_lat) begin
          r = $urandom;
          cu_conv_DONE = r[0];
          drain_done = r[1];
          scramble_cfg();
        end
        tick();
        perf_exp++;
        cu_slave_select = 1'b1;
        cu_conv_DONE = 1'b0;
        drain_done = 1'b0;
      end
      for (int j = 0; j <= done_lat; j++) begin
        chk("run_load", 32'(Load_kernel_BRAM), 0);
        chk("run_drain", 32'(drain_req), 0);
        chk("run_busy", 32'(busy), 1);
        chk("run_idx", 32'(out_ch_idx), 32'(c));
        if (c == abort_ch && j == done_lat / 2) begin
          abort = 1'b1;
          tick();
          abort = 1'b0;
          chk("abort_rstn", 32'(cu_reset_n), 0);
          chk("abort_busy", 32'(busy), 0);
          chk("abort_done", 32'(layer_done), 0);
          chk("abort_load", 32'(Load_kernel_BRAM), 0);
          tick();
          chk("abort_rel", 32'(cu_reset_n), 1);
          chk("abort_idle", 32'(busy), 0);
          chk("abort_nodone", 32'(layer_done), 0);
          return;
        end
        cu_conv_DONE = (j == done_lat);
        if (noisy && j < done_lat) begin
          r = $urandom;
          drain_done = r[0];
          start = r[1];
          scramble_cfg();
        end
        tick();
        perf_exp++;
        cu_conv_DONE = 1'b0;
        drain_done = 1'b0;
        start = 1'b0;
      end
      for (int j = 0; j <= drain_lat; j++) begin
        chk("drain_req", 32'(drain_req), 1);
        chk("drain_idx", 32'(out_ch_idx), 32'(c));
        chk("drain_nodone", 32'(layer_done), 0);
        drain_done = (j == drain_lat);
        if (noisy && j < drain_lat) begin
          r = $urandom;
          cu_conv_DONE = r[0];
        end
        tick();
        perf_exp++;
        drain_done = 1'b0;
        cu_conv_DONE = 1'b0;
      end
    end
    chk("fin_done", 32'(layer_done), 1);
    chk("fin_busy", 32'(busy), 1);
    chk("fin_drain", 32'(drain_req), 0);
    chk("fin_idx", 32'(out_ch_idx), 32'(n_eff - 1));
    tick();
    perf_exp++;
    chk("post_done", 32'(layer_done), 0);
    chk("post_busy", 32'(busy), 0);
    chk("post_rstn", 32'(cu_reset_n), 1);
    chk("post_idx", 32'(out_ch_idx), 32'(n_eff - 1));
    check_cfg();
`ifdef CONV_SCHED_PERF_EN
    chk("perf", perf_cycles, 32'(perf_exp));
`endif
  endtask

  initial begin
    logic [31:0] r;
    Reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    cfg_channel_choose = 2'd0;
    cfg_image_choose = 3'd0;
    cfg_out_channels = '0;
    cu_slave_select = 1'b1;
    cu_conv_DONE = 1'b0;
    drain_done = 1'b0;
    exp_ch = 2'd0;
    exp_img = 3'd0;
    tick();
    tick();
    chk("rst_cu_reset_n", 32'(cu_reset_n), 1);
    chk("rst_load_kernel", 32'(Load_kernel_BRAM), 0);
    chk("rst_drain_req", 32'(drain_req), 0);
    chk("rst_busy_out", 32'(busy), 0);
    chk("rst_layer_done", 32'(layer_done), 0);
    chk("rst_out_ch_idx", 32'(out_ch_idx), 0);
    check_cfg();
    Reset = 1'b0;
    tick();

    run_layer(2'd1, 3'd3, 3, 2, 50, 10, 1'b0, -1);
    run_layer(2'd2, 3'd1, 0, 1, 3, 2, 1'b0, -1);
    run_layer(2'd0, 3'd3, 2, 1, 5, 1, 1'b1, -1);
    run_layer(2'd1, 3'd2, 3, 1, 6, 2, 1'b0, 1);
    run_layer(2'd1, 3'd2, 2, 0, 2, 0, 1'b1, -1);
    run_layer(2'd0, 3'd0, 1, 0, 0, 0, 1'b0, -1);
`ifdef CONV_SCHED_PERF_EN
    chk("perf_zero_lat", perf_cycles, 32'd8);
`endif
    run_layer(2'd3, 3'd7, 2, 0, 0, 0, 1'b1, -1);

    for (int i = 0; i < 25; i++) begin
      r = $urandom;
      run_layer(r[1:0], r[4:2], int'(r[7:5] % 5), int'(r[9:8]), int'(r[13:10]),
                int'(r[16:14]), r[17], (r[20:18] == 3'd0) ? int'(r[22:21]) : -1);
    end

    cfg_channel_choose = 2'd2;
    cfg_image_choose = 3'd5;
    cfg_out_channels = 9'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < RST_CYCLES; k++) tick();
    cu_slave_select = 1'b0;
    tick();
    cu_slave_select = 1'b1;
    tick();
    chk("pre_reset_busy", 32'(busy), 1);
    Reset = 1'b1;
    #1;
    exp_ch = 2'd0;
    exp_img = 3'd0;
    chk("async_rstn", 32'(cu_reset_n), 1);
    chk("async_busy", 32'(busy), 0);
    chk("async_load", 32'(Load_kernel_BRAM), 0);
    chk("async_idx", 32'(out_ch_idx), 0);
    check_cfg();
`ifdef CONV_SCHED_PERF_EN
    chk("async_perf", perf_cycles, 0);
`endif
    tick();
    Reset = 1'b0;
    tick();
    run_layer(2'd1, 3'd4, 2, 1, 4, 3, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
